// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, NOP encoding and fetch state shared by fetch/decode/execute
package cpu_pkg;
  localparam int PC_W = 16;
  localparam int IR_W = 16;
  localparam logic [IR_W-1:0] NOP_IR = '0;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with load/increment/hold, wrapping modulo 2^PC_W
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld,
  input  logic            inc,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (ld) pc <= d;
    else if (inc) pc <= pc + PC_W'(1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC ownership, req/ack instruction fetch, stall skid and branch flush
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [IR_W-1:0] ir,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc_out
);
  fetch_state_e state, state_n;
  logic [PC_W-1:0] pc, pc_out_n, flush_addr, flush_addr_n;
  logic [IR_W-1:0] ir_n, skid, skid_n;
  logic valid_n, pc_ld, pc_inc;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .ld(pc_ld), .inc(pc_inc), .d(br_target), .pc(pc)
  );
  // the abandoned request keeps its own address since pc already holds the target
  assign imem_req  = state == FETCH || state == FLUSH;
  assign imem_addr = state == FLUSH ? flush_addr : pc;
  always_comb begin
    state_n      = state;
    ir_n         = ir;
    valid_n      = ir_valid;
    pc_out_n     = pc_out;
    skid_n       = skid;
    flush_addr_n = flush_addr;
    pc_ld        = 1'b0;
    pc_inc       = 1'b0;
    if (br_taken) begin
      ir_n         = NOP_IR;
      valid_n      = 1'b0;
      skid_n       = '0;
      pc_ld        = 1'b1;
      state_n      = imem_req && !imem_ack ? FLUSH : FETCH;
      flush_addr_n = state == FETCH ? pc : flush_addr;
    end else begin
      case (state)
        IDLE: state_n = FETCH;
        FETCH: if (imem_ack) begin
          pc_inc = 1'b1;
          if (stall) begin
            skid_n  = imem_rdata;
            state_n = HOLD;
          end else begin
            ir_n     = imem_rdata;
            pc_out_n = pc;
            valid_n  = 1'b1;
          end
        end
        HOLD: if (!stall) begin
          ir_n     = skid;
          pc_out_n = pc - PC_W'(1);
          valid_n  = 1'b1;
          state_n  = FETCH;
        end
        FLUSH: state_n = imem_ack ? FETCH : FLUSH;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      ir         <= NOP_IR;
      ir_valid   <= 1'b0;
      pc_out     <= '0;
      skid       <= '0;
      flush_addr <= '0;
    end else begin
      state      <= state_n;
      ir         <= ir_n;
      ir_valid   <= valid_n;
      pc_out     <= pc_out_n;
      skid       <= skid_n;
      flush_addr <= flush_addr_n;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus async-reset sequence; second DUT covers PC wrap
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, br = 1'b0, ack = 1'b0;
  logic [15:0] tgt = '0;
  logic        req, req2, valid, valid2;
  logic [15:0] addr, addr2, rdata, rdata2, ir, ir2, pc_out, pc_out2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign rdata  = addr ^ 16'hA5A5;
  assign rdata2 = addr2 ^ 16'hA5A5;
  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br), .br_target(tgt),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .ir(ir), .ir_valid(valid), .pc_out(pc_out)
  );
  instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br), .br_target(tgt),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack), .imem_rdata(rdata2),
    .ir(ir2), .ir_valid(valid2), .pc_out(pc_out2)
  );
  typedef struct {
    logic stall, br; logic [15:0] tgt; logic ack;
    logic req; logic [15:0] addr, ir; logic valid; logic [15:0] pc_out;
  } vec_t;
  typedef struct {logic [15:0] addr, ir, pc_out;} wrap_t;
  vec_t  v[27];
  wrap_t w[3];
  task automatic chk(input string name, input int idx, input logic [49:0] act, input logic [49:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got {req,addr,ir,valid,pc_out}=%h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //        stall br tgt       ack  req addr      ir        vld pc_out
    v[0]  = '{0, 0, 16'h0000, 0,   1, 16'h0000, 16'h0000, 0, 16'h0000};
    v[1]  = '{0, 0, 16'h0000, 1,   1, 16'h0001, 16'hA5A5, 1, 16'h0000};
    v[2]  = '{0, 0, 16'h0000, 1,   1, 16'h0002, 16'hA5A4, 1, 16'h0001};
    v[3]  = '{0, 0, 16'h0000, 1,   1, 16'h0003, 16'hA5A7, 1, 16'h0002};
    v[4]  = '{0, 0, 16'h0000, 0,   1, 16'h0003, 16'hA5A7, 1, 16'h0002};
    v[5]  = '{0, 0, 16'h0000, 0,   1, 16'h0003, 16'hA5A7, 1, 16'h0002};
    v[6]  = '{0, 0, 16'h0000, 0,   1, 16'h0003, 16'hA5A7, 1, 16'h0002};
    v[7]  = '{0, 0, 16'h0000, 1,   1, 16'h0004, 16'hA5A6, 1, 16'h0003};
    v[8]  = '{0, 0, 16'h0000, 1,   1, 16'h0005, 16'hA5A1, 1, 16'h0004};
    v[9]  = '{1, 0, 16'h0000, 1,   0, 16'h0006, 16'hA5A1, 1, 16'h0004};
    v[10] = '{1, 0, 16'h0000, 0,   0, 16'h0006, 16'hA5A1, 1, 16'h0004};
    v[11] = '{0, 0, 16'h0000, 0,   1, 16'h0006, 16'hA5A0, 1, 16'h0005};
    v[12] = '{0, 0, 16'h0000, 1,   1, 16'h0007, 16'hA5A3, 1, 16'h0006};
    v[13] = '{0, 1, 16'h0040, 0,   1, 16'h0007, 16'h0000, 0, 16'h0006};
    v[14] = '{0, 0, 16'h0000, 0,   1, 16'h0007, 16'h0000, 0, 16'h0006};
    v[15] = '{0, 0, 16'h0000, 1,   1, 16'h0040, 16'h0000, 0, 16'h0006};
    v[16] = '{0, 0, 16'h0000, 1,   1, 16'h0041, 16'hA5E5, 1, 16'h0040};
    v[17] = '{0, 1, 16'h0080, 1,   1, 16'h0080, 16'h0000, 0, 16'h0040};
    v[18] = '{0, 0, 16'h0000, 1,   1, 16'h0081, 16'hA525, 1, 16'h0080};
    v[19] = '{0, 1, 16'h0100, 0,   1, 16'h0081, 16'h0000, 0, 16'h0080};
    v[20] = '{0, 1, 16'h0200, 0,   1, 16'h0081, 16'h0000, 0, 16'h0080};
    v[21] = '{0, 0, 16'h0000, 1,   1, 16'h0200, 16'h0000, 0, 16'h0080};
    v[22] = '{0, 0, 16'h0000, 1,   1, 16'h0201, 16'hA7A5, 1, 16'h0200};
    v[23] = '{1, 0, 16'h0000, 0,   1, 16'h0201, 16'hA7A5, 1, 16'h0200};
    v[24] = '{1, 0, 16'h0000, 1,   0, 16'h0202, 16'hA7A5, 1, 16'h0200};
    v[25] = '{1, 1, 16'h0300, 0,   1, 16'h0300, 16'h0000, 0, 16'h0200};
    v[26] = '{0, 0, 16'h0000, 1,   1, 16'h0301, 16'hA6A5, 1, 16'h0300};
    w[0] = '{16'hFFFF, 16'h0000, 16'h0000};
    w[1] = '{16'h0000, 16'h5A5A, 16'hFFFF};
    w[2] = '{16'h0001, 16'hA5A5, 16'h0000};
    tick();
    tick();
    chk("reset", 0, {req, addr, ir, valid, pc_out}, {1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000});
    chk("reset_wrap", 0, {req2, addr2, ir2, valid2, pc_out2}, {1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000});
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) begin
      stall = v[i].stall;
      br    = v[i].br;
      tgt   = v[i].tgt;
      ack   = v[i].ack;
      tick();
      chk("vec", i, {req, addr, ir, valid, pc_out}, {v[i].req, v[i].addr, v[i].ir, v[i].valid, v[i].pc_out});
      if (i < 3)
        chk("wrap", i, {req2, addr2, ir2, valid2, pc_out2}, {1'b1, w[i].addr, w[i].ir, i > 0, w[i].pc_out});
    end
    stall = 1'b0;
    br    = 1'b0;
    ack   = 1'b0;
    tick();
    chk("pending", 0, {req, addr, ir, valid, pc_out}, {1'b1, 16'h0301, 16'hA6A5, 1'b1, 16'h0300});
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 0, {req, addr, ir, valid, pc_out}, {1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000});
    tick();
    rst_n = 1'b1;
    chk("rst_idle", 0, {req, addr, ir, valid, pc_out}, {1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000});
    tick();
    chk("refetch", 0, {req, addr, ir, valid, pc_out}, {1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000});
    ack = 1'b1;
    tick();
    chk("refetch_ack", 0, {req, addr, ir, valid, pc_out}, {1'b1, 16'h0001, 16'hA5A5, 1'b1, 16'h0000});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
